// File: rtl/register_file.sv
// register_file -- 32 x 32-bit architectural register file with rename state
// (busy bit + 4-bit ROB tag per register) for an out-of-order core.
// Two combinational read ports, one rename port, one commit port, and a
// mispredict flush that drops all pending producers.
// Optional feature: define REGFILE_BYPASS_EN to forward a committing value
// to a read port in the same cycle it commits.
module register_file (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jp_wrong,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic [31:0] rs1_val,
  output logic [31:0] rs2_val,
  output logic [3:0]  rs1_idx,
  output logic [3:0]  rs2_idx,
  input  logic        upd_flag,
  input  logic [3:0]  upd_idx,
  input  logic [4:0]  upd_rd,
  input  logic        write_flag,
  input  logic [3:0]  write_idx,
  input  logic [4:0]  write_rd,
  input  logic [31:0] new_val
);

  logic [31:0] regs [32];
  logic [3:0]  tags [32];
  logic [31:0] busy;

  logic commit_en;
  logic rename_en;

  // x0 is never written, so its reset value of zero is what it always reads.
  assign commit_en = write_flag && rdy && !jp_wrong && (write_rd != 5'd0);
  assign rename_en = upd_flag   && rdy && !jp_wrong && (upd_rd   != 5'd0);

  // State update: reset, flush, then commit followed by rename.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the storage arrays are reset here on purpose -- software may read
      // any register before writing it and must see zero, so this cannot be a RAM macro.
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
        tags[i] <= '0;
      end
      busy <= '0;
    end else if (jp_wrong) begin
      // Every in-flight producer is squashed; committed values and tags stay.
      busy <= '0;
    end else begin
      if (commit_en) begin
        regs[write_rd] <= new_val;
        // A tag mismatch means a younger rename owns the register; leave it busy.
        if (tags[write_rd] == write_idx) begin
          busy[write_rd] <= 1'b0;
        end
      end
      // NOTE: non-blocking assignments make the later rename override the
      // commit's busy clear on the same register, while reads still see the old state.
      if (rename_en) begin
        busy[upd_rd] <= 1'b1;
        tags[upd_rd] <= upd_idx;
      end
    end
  end

  // Read port 1: start-of-cycle state, optionally bypassed from the commit port.
  always_comb begin
    // NOTE: every output gets a default before any conditional override, so no latch is inferred.
    rs1_val  = regs[rs1];
    rs1_busy = busy[rs1];
    rs1_idx  = tags[rs1];
`ifdef REGFILE_BYPASS_EN
    if (write_flag && !jp_wrong && (rs1 != 5'd0) && (write_rd == rs1) &&
        busy[rs1] && (tags[rs1] == write_idx)) begin
      rs1_val  = new_val;
      rs1_busy = 1'b0;
    end
`endif
  end

  // Read port 2: same behaviour as port 1.
  always_comb begin
    rs2_val  = regs[rs2];
    rs2_busy = busy[rs2];
    rs2_idx  = tags[rs2];
`ifdef REGFILE_BYPASS_EN
    if (write_flag && !jp_wrong && (rs2 != 5'd0) && (write_rd == rs2) &&
        busy[rs2] && (tags[rs2] == write_idx)) begin
      rs2_val  = new_val;
      rs2_busy = 1'b0;
    end
`endif
  end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file -- directed self-checking bench for register_file.
// Inputs change on the falling edge; outputs are sampled 1 ns later, so a
// sample shows the state left by the previous rising edge (plus any bypass).
module tb_register_file;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        jp_wrong;
  logic [4:0]  rs1, rs2;
  logic        rs1_busy, rs2_busy;
  logic [31:0] rs1_val, rs2_val;
  logic [3:0]  rs1_idx, rs2_idx;
  logic        upd_flag;
  logic [3:0]  upd_idx;
  logic [4:0]  upd_rd;
  logic        write_flag;
  logic [3:0]  write_idx;
  logic [4:0]  write_rd;
  logic [31:0] new_val;

  int tests = 0;
  int fails = 0;

  register_file dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .jp_wrong   (jp_wrong),
    .rs1        (rs1),
    .rs2        (rs2),
    .rs1_busy   (rs1_busy),
    .rs2_busy   (rs2_busy),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .rs1_idx    (rs1_idx),
    .rs2_idx    (rs2_idx),
    .upd_flag   (upd_flag),
    .upd_idx    (upd_idx),
    .upd_rd     (upd_rd),
    .write_flag (write_flag),
    .write_idx  (write_idx),
    .write_rd   (write_rd),
    .new_val    (new_val)
  );

  always #5 clk = ~clk;

  // Drop all request strobes, keep rdy high.
  task automatic idle();
    rdy        = 1'b1;
    jp_wrong   = 1'b0;
    upd_flag   = 1'b0;
    upd_idx    = 4'd0;
    upd_rd     = 5'd0;
    write_flag = 1'b0;
    write_idx  = 4'd0;
    write_rd   = 5'd0;
    new_val    = 32'd0;
  endtask

  // One rising edge, returning at the following falling edge.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rename(input logic [4:0] rd, input logic [3:0] idx);
    upd_flag = 1'b1;
    upd_rd   = rd;
    upd_idx  = idx;
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    rs1 = 5'd5;
    rs2 = 5'd0;
    repeat (2) @(negedge clk);
    #1;
    tests++; if (rs1_val !== 32'd0 || rs1_busy !== 1'b0 || rs1_idx !== 4'd0) begin
      fails++; $display("FAIL reset_outputs: val=%h busy=%b idx=%h expected 0/0/0", rs1_val, rs1_busy, rs1_idx);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    #1;
    tests++; if (rs1_val !== 32'd0 || rs1_busy !== 1'b0) begin
      fails++; $display("FAIL x5_after_reset: val=%h busy=%b expected 0/0", rs1_val, rs1_busy);
    end
  endtask

  task automatic test_x0();
    upd_flag   = 1'b1; upd_rd   = 5'd0; upd_idx   = 4'd3;
    write_flag = 1'b1; write_rd = 5'd0; write_idx = 4'd3; new_val = 32'hFFFF_FFFF;
    tick();
    idle();
    rs1 = 5'd0;
    #1;
    tests++; if (rs1_busy !== 1'b0 || rs1_val !== 32'd0 || rs1_idx !== 4'd0) begin
      fails++; $display("FAIL x0_ignored: busy=%b val=%h idx=%h expected 0/0/0", rs1_busy, rs1_val, rs1_idx);
    end
  endtask

  task automatic test_rename_commit();
    rename(5'd5, 4'd7);
    rs1 = 5'd5;
    #1;
    tests++; if (rs1_busy !== 1'b1 || rs1_idx !== 4'd7) begin
      fails++; $display("FAIL x5_renamed: busy=%b idx=%h expected 1/7", rs1_busy, rs1_idx);
    end
    write_flag = 1'b1; write_rd = 5'd5; write_idx = 4'd7; new_val = 32'hDEAD_BEEF;
    tick();
    idle();
    #1;
    tests++; if (rs1_busy !== 1'b0 || rs1_val !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL x5_committed: busy=%b val=%h expected 0/deadbeef", rs1_busy, rs1_val);
    end
  endtask

  task automatic test_stale_commit();
    rename(5'd6, 4'd2);
    rename(5'd6, 4'd9);
    write_flag = 1'b1; write_rd = 5'd6; write_idx = 4'd2; new_val = 32'h11;
    tick();
    idle();
    rs2 = 5'd6;
    #1;
    tests++; if (rs2_busy !== 1'b1 || rs2_idx !== 4'd9 || rs2_val !== 32'h11) begin
      fails++; $display("FAIL x6_stale_commit: busy=%b idx=%h val=%h expected 1/9/11", rs2_busy, rs2_idx, rs2_val);
    end
    write_flag = 1'b1; write_rd = 5'd6; write_idx = 4'd9; new_val = 32'h22;
    tick();
    idle();
    #1;
    tests++; if (rs2_busy !== 1'b0 || rs2_val !== 32'h22) begin
      fails++; $display("FAIL x6_final_commit: busy=%b val=%h expected 0/22", rs2_busy, rs2_val);
    end
  endtask

  task automatic test_same_cycle();
    rename(5'd7, 4'd1);
    rs1 = 5'd7;
    upd_flag   = 1'b1; upd_rd   = 5'd7; upd_idx   = 4'd4;
    write_flag = 1'b1; write_rd = 5'd7; write_idx = 4'd1; new_val = 32'h55;
    #1;
    tests++; if (rs1_idx !== 4'd1) begin
      fails++; $display("FAIL x7_read_prior_mapping: idx=%h expected 1", rs1_idx);
    end
    tick();
    idle();
    #1;
    tests++; if (rs1_busy !== 1'b1 || rs1_idx !== 4'd4 || rs1_val !== 32'h55) begin
      fails++; $display("FAIL x7_rename_wins: busy=%b idx=%h val=%h expected 1/4/55", rs1_busy, rs1_idx, rs1_val);
    end
  endtask

  task automatic test_flush();
    rename(5'd8, 4'd1);
    rename(5'd9, 4'd2);
    rename(5'd10, 4'd3);
    jp_wrong   = 1'b1;
    write_flag = 1'b1; write_rd = 5'd8;  write_idx = 4'd1; new_val = 32'h99;
    upd_flag   = 1'b1; upd_rd   = 5'd11; upd_idx   = 4'd5;
    tick();
    idle();
    rs1 = 5'd8; rs2 = 5'd9;
    #1;
    tests++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b0) begin
      fails++; $display("FAIL flush_x8_x9_busy: busy=%b/%b expected 0/0", rs1_busy, rs2_busy);
    end
    tests++; if (rs1_val !== 32'd0) begin
      fails++; $display("FAIL flush_x8_unchanged: val=%h expected 0", rs1_val);
    end
    rs1 = 5'd10; rs2 = 5'd11;
    #1;
    tests++; if (rs1_busy !== 1'b0 || rs1_idx !== 4'd3) begin
      fails++; $display("FAIL flush_x10: busy=%b idx=%h expected 0/3", rs1_busy, rs1_idx);
    end
    tests++; if (rs2_busy !== 1'b0 || rs2_idx !== 4'd0) begin
      fails++; $display("FAIL flush_x11_rename_dropped: busy=%b idx=%h expected 0/0", rs2_busy, rs2_idx);
    end
  endtask

  task automatic test_bypass();
    rename(5'd12, 4'd5);
    rs1 = 5'd12;
    write_flag = 1'b1; write_rd = 5'd12; write_idx = 4'd5; new_val = 32'h1234;
    #1;
`ifdef REGFILE_BYPASS_EN
    tests++; if (rs1_val !== 32'h1234 || rs1_busy !== 1'b0) begin
      fails++; $display("FAIL bypass_same_cycle: val=%h busy=%b expected 1234/0", rs1_val, rs1_busy);
    end
`else
    tests++; if (rs1_val !== 32'd0 || rs1_busy !== 1'b1) begin
      fails++; $display("FAIL no_bypass_same_cycle: val=%h busy=%b expected 0/1", rs1_val, rs1_busy);
    end
`endif
    tick();
    idle();
    #1;
    tests++; if (rs1_val !== 32'h1234 || rs1_busy !== 1'b0) begin
      fails++; $display("FAIL x12_next_cycle: val=%h busy=%b expected 1234/0", rs1_val, rs1_busy);
    end
  endtask

  task automatic test_rdy_hold();
    rdy        = 1'b0;
    upd_flag   = 1'b1; upd_rd   = 5'd13; upd_idx   = 4'd6;
    write_flag = 1'b1; write_rd = 5'd5;  write_idx = 4'd7; new_val = 32'hAAAA_AAAA;
    rs1 = 5'd5; rs2 = 5'd13;
    repeat (2) tick();
    #1;
    tests++; if (rs1_val !== 32'hDEAD_BEEF) begin
      fails++; $display("FAIL rdy_low_x5_held: val=%h expected deadbeef", rs1_val);
    end
    tests++; if (rs2_busy !== 1'b0 || rs2_idx !== 4'd0) begin
      fails++; $display("FAIL rdy_low_x13_held: busy=%b idx=%h expected 0/0", rs2_busy, rs2_idx);
    end
    idle();
  endtask

  task automatic test_async_reset();
    rename(5'd14, 4'd8);
    rs1 = 5'd14; rs2 = 5'd5;
    #2;
    rst = 1'b1;
    #1;
    tests++; if (rs1_busy !== 1'b0 || rs1_idx !== 4'd0 || rs2_val !== 32'd0) begin
      fails++; $display("FAIL async_reset_immediate: busy=%b idx=%h val=%h expected 0/0/0", rs1_busy, rs1_idx, rs2_val);
    end
    @(negedge clk);
    rst = 1'b0;
    rename(5'd15, 4'd3);
    rs2 = 5'd15;
    #1;
    tests++; if (rs1_busy !== 1'b0 || rs2_busy !== 1'b1 || rs2_idx !== 4'd3) begin
      fails++; $display("FAIL post_reset_rename: x14busy=%b x15busy=%b x15idx=%h expected 0/1/3", rs1_busy, rs2_busy, rs2_idx);
    end
  endtask

  initial begin
    test_reset();
    test_x0();
    test_rename_commit();
    test_stale_commit();
    test_same_cycle();
    test_flush();
    test_bypass();
    test_rdy_hold();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 rdy  in  1  global ready; low = hold all state.
REQ-004 jp_wrong  in  1  ROB mispredict flush, one-cycle pulse.
REQ-005 rs1, rs2  in  5 each  decoder source register numbers.
REQ-006 rs1_busy, rs2_busy  out  1 each  source value pending in ROB.
REQ-007 rs1_val, rs2_val  out  32 each  architectural register value.
REQ-008 rs1_idx, rs2_idx  out  4 each  ROB tag of pending producer, sent to ROB.
REQ-009 upd_flag  in  1; upd_idx  in  4; upd_rd  in  5  rename: newly dispatched rd and its ROB tag.
REQ-010 write_flag  in  1; write_idx  in  4; write_rd  in  5; new_val  in  32  commit from ROB head.

Function
REQ-011 Storage SHALL be 32 x 32-bit regs, 32 busy bits, and 32 x 4-bit tags.
REQ-012 Read ports SHALL be combinational: rsN_val = regs[rsN], rsN_busy = busy[rsN], rsN_idx = tag[rsN]; they reflect start-of-cycle state except under REQ-021.
REQ-013 x0 SHALL read 0, busy 0, tag 0; renames and commits to x0 SHALL be ignored.
REQ-014 Commit (write_flag & rdy & !jp_wrong, write_rd != 0) SHALL write regs[write_rd] <= new_val at the clock edge.
REQ-015 On commit, busy[write_rd] SHALL clear only if tag[write_rd] == write_idx; a mismatch means a younger producer exists, and busy is kept.
REQ-016 Rename (upd_flag & rdy & !jp_wrong, upd_rd != 0) SHALL set busy[upd_rd] <= 1 and tag[upd_rd] <= upd_idx.
REQ-017 If rename and commit target the same register in one cycle, the rename SHALL win for busy and tag, and the commit value SHALL still be written to regs.
REQ-018 A same-cycle rename SHALL NOT affect that cycle's reads, so an instruction with rd == rs1 sees the prior mapping.
REQ-019 When jp_wrong is high, all busy bits SHALL clear at the edge; write_flag and upd_flag SHALL be ignored that cycle; regs and tags SHALL be unchanged.
REQ-020 With rdy low and jp_wrong low, no state SHALL change; reads remain valid.

Reset
REQ-022 rst high SHALL immediately clear all regs, busy bits, and tags to 0, independent of clk and rdy.
REQ-023 While rst is high, all outputs SHALL read 0 (val 0, busy 0, idx 0).
REQ-024 Reset mid-operation SHALL discard pending renames; the first post-reset edge behaves as REQ-014..REQ-020.

Configuration
REQ-021 With REGFILE_BYPASS_EN defined, if write_flag & !jp_wrong & write_rd == rsN != 0 and busy[rsN] with tag[rsN] == write_idx, then rsN_val SHALL be new_val and rsN_busy SHALL be 0 in the same cycle. Without the macro there SHALL be no bypass, and the value becomes visible the cycle after commit.

Verification
REQ-025 Reset, then read x5 -> val 0, busy 0; drive upd x0 tag 3, then read x0 -> busy 0, val 0.
REQ-026 upd x5 tag 7; next cycle read x5 -> busy 1, idx 7; commit x5 idx 7 val 0xDEADBEEF; next cycle -> busy 0, val 0xDEADBEEF.
REQ-027 upd x6 tag 2, then upd x6 tag 9; commit x6 idx 2 val 0x11 -> busy 1, idx 9, val 0x11; commit idx 9 val 0x22 -> busy 0, val 0x22.
REQ-028 Same cycle: upd x7 tag 4 and commit x7 idx 1 val 0x55 (busy, tag 1) -> next cycle busy 1, idx 4, val 0x55.
REQ-029 x8..x10 busy; pulse jp_wrong with write_flag (x8, matching tag, val 0x99) and upd x11 -> busy all 0, x8 unchanged, x11 not busy.
REQ-030 Bypass: x12 busy tag 5, rs1 = 12, commit x12 idx 5 val 0x1234 -> with REGFILE_BYPASS_EN same-cycle val 0x1234, busy 0; without it busy 1 that cycle and val 0x1234 the next; also rdy low holds all state.
